// File: rtl/load_store_unit.sv
// Initiator side of the MEM-stage data-memory port: one load/store at a time, sub-word
// stores via read-modify-write. Define LSU_STATS_EN to add saturating load/store/error counters.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
`ifdef LSU_STATS_EN
  ,
  output logic [15:0] loadCount,
  output logic [15:0] storeCount,
  output logic [15:0] errCount
`endif
);

  localparam logic [1:0]  SZ_BYTE     = 2'b00;
  localparam logic [1:0]  SZ_HALF     = 2'b01;
  localparam logic [1:0]  SZ_WORD     = 2'b10;
  localparam logic [1:0]  SZ_ILL      = 2'b11;
  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_rword;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_data;
  logic [31:0] r_mem_addr;

  logic [31:0] w_word_idx;
  logic        w_req_err;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merge_word;

  assign w_word_idx = {2'b00, reqAddr[31:2]};
  assign w_req_err  = (reqSize == SZ_ILL)
                   || ((reqSize == SZ_HALF) && reqAddr[0])
                   || ((reqSize == SZ_WORD) && (reqAddr[1:0] != 2'b00))
                   || (w_word_idx >= MEM_WORDS_L);

  // Big-endian lane pick: lane 0 is the most significant byte of the word.
  always_comb begin
    w_lane_byte = 8'h00;
    case (r_lane)
      2'd0:    w_lane_byte = memReadData[31:24];
      2'd1:    w_lane_byte = memReadData[23:16];
      2'd2:    w_lane_byte = memReadData[15:8];
      default: w_lane_byte = memReadData[7:0];
    endcase
    w_lane_half = r_lane[1] ? memReadData[15:0] : memReadData[31:16];
  end

  always_comb begin
    w_load_val = memReadData;
    case (r_size)
      SZ_BYTE: w_load_val = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
      SZ_HALF: w_load_val = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
      default: w_load_val = memReadData;
    endcase
  end

  always_comb begin
    w_merge_word = r_rword;
    case (r_size)
      SZ_BYTE: begin
        case (r_lane)
          2'd0:    w_merge_word[31:24] = r_wdata[7:0];
          2'd1:    w_merge_word[23:16] = r_wdata[7:0];
          2'd2:    w_merge_word[15:8]  = r_wdata[7:0];
          default: w_merge_word[7:0]   = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_lane[1]) w_merge_word[15:0]  = r_wdata[15:0];
        else           w_merge_word[31:16] = r_wdata[15:0];
      end
      default: w_merge_word = r_wdata;
    endcase
  end

  // Strobes decode from the state register alone so reset kills them asynchronously.
  assign reqReady = (r_state == S_IDLE);
  assign memRead  = (r_state == S_LOAD)  || (r_state == S_RMW_RD);
  assign memWrite = (r_state == S_STORE) || (r_state == S_RMW_WR);

  always_comb begin
    memWriteData = 32'h0;
    case (r_state)
      S_STORE:  memWriteData = r_wdata;
      S_RMW_WR: memWriteData = w_merge_word;
      default:  memWriteData = 32'h0;
    endcase
  end

  assign memAddress = r_mem_addr;
  assign respValid  = r_resp_valid;
  assign respErr    = r_resp_err;
  assign respData   = r_resp_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 32'h0;
      r_rword      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= 32'h0;
      r_mem_addr   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (reqValid) begin
            r_write    <= reqWrite;
            r_size     <= reqSize;
            r_signed   <= reqSigned;
            r_lane     <= reqAddr[1:0];
            r_wdata    <= reqWData;
            r_mem_addr <= w_word_idx;
            if (w_req_err) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'h0;
            end else if (!reqWrite) begin
              r_state <= S_LOAD;
            end else if (reqSize == SZ_WORD) begin
              r_state <= S_STORE;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        S_RMW_RD: begin
          r_rword <= memReadData;
          r_state <= S_RMW_WR;
        end
        S_LOAD, S_STORE, S_RMW_WR: begin
          if (r_state == S_LOAD) r_rword <= memReadData;
          r_state      <= S_DONE;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_data  <= r_write ? 32'h0 : w_load_val;
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_addr   <= 32'h0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  logic [15:0] r_load_cnt;
  logic [15:0] r_store_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_cnt  <= 16'h0;
      r_store_cnt <= 16'h0;
      r_err_cnt   <= 16'h0;
    end else if (r_state == S_DONE) begin
      if (r_resp_err) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'h1;
      end else if (r_write) begin
        if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'h1;
      end else begin
        if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'h1;
      end
    end
  end

  assign loadCount  = r_load_cnt;
  assign storeCount = r_store_cnt;
  assign errCount   = r_err_cnt;
`endif

endmodule
